// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// Holds the FSM state enum, the default widths and the HALT opcode.
package fetch_pkg;

  localparam int FETCH_ADDR_W = 8;
  localparam int FETCH_DATA_W = 8;

  localparam logic [FETCH_DATA_W-1:0] FETCH_HALT_OP = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    HALTED
  } fetch_state_t;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register: load beats increment, otherwise hold.
// Ports: clk_i, rst_i (async, active-high), load_i/load_val_i, inc_i, pc_o.
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter int                ADDR_W     = FETCH_ADDR_W,
  parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] load_val_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] pc_o
);

  localparam logic [ADDR_W-1:0] ONE = 1;

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  // Increment wraps modulo 2**ADDR_W with no flag.
  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_val_i;
    end else if (inc_i) begin
      pc_d = pc_q + ONE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q <= START_ADDR;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: owns the PC, reads the combinational instruction memory
// and registers each word into a valid/ready stage; handles branch and halt.
// Ports: clk, reset (async, active-high), start, imem_addr, imem_data,
//   branch_valid, branch_target, instr_valid, instr_ready, instr_out,
//   instr_pc, halted. With FETCH_PERF_EN defined: perf_fetch_cnt,
//   perf_stall_cnt (16-bit saturating counters).
module instr_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int                ADDR_W      = FETCH_ADDR_W,
  parameter int                DATA_W      = FETCH_DATA_W,
  parameter logic [ADDR_W-1:0] START_ADDR  = '0,
  parameter logic [DATA_W-1:0] HALT_OPCODE = FETCH_HALT_OP
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_out,
  output logic [ADDR_W-1:0] instr_pc,
`ifdef FETCH_PERF_EN
  output logic [15:0]       perf_fetch_cnt,
  output logic [15:0]       perf_stall_cnt,
`endif
  output logic              halted
);

  fetch_state_t state_q;
  fetch_state_t state_d;

  logic              valid_q;
  logic              valid_d;
  logic [DATA_W-1:0] out_q;
  logic [DATA_W-1:0] out_d;
  logic [ADDR_W-1:0] ipc_q;
  logic [ADDR_W-1:0] ipc_d;

  logic              pc_load;
  logic [ADDR_W-1:0] pc_load_val;
  logic              pc_inc;
  logic [ADDR_W-1:0] pc;

  logic free;
  logic br;
  logic xfer;

  fetch_pc_reg #(
    .ADDR_W    (ADDR_W),
    .START_ADDR(START_ADDR)
  ) u_pc (
    .clk_i     (clk),
    .rst_i     (reset),
    .load_i    (pc_load),
    .load_val_i(pc_load_val),
    .inc_i     (pc_inc),
    .pc_o      (pc)
  );

  assign free = !valid_q || instr_ready;
  assign br   = branch_valid &&
                (state_q == FETCH || state_q == DRAIN);
  // A flushed word is not a delivery even if ready was high.
  assign xfer = valid_q && instr_ready && !br;

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    out_d       = out_q;
    ipc_d       = ipc_q;
    pc_load     = 1'b0;
    pc_load_val = START_ADDR;
    pc_inc      = 1'b0;
    if (br) begin
      valid_d     = 1'b0;
      pc_load     = 1'b1;
      pc_load_val = branch_target;
      state_d     = FETCH;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d = FETCH;
          end
        end
        FETCH: begin
          if (free) begin
            out_d   = imem_data;
            ipc_d   = pc;
            valid_d = 1'b1;
            pc_inc  = 1'b1;
            if (imem_data == HALT_OPCODE) begin
              state_d = DRAIN;
            end
          end
        end
        DRAIN: begin
          if (valid_q && instr_ready) begin
            valid_d = 1'b0;
            state_d = HALTED;
          end
        end
        HALTED: begin
          valid_d = 1'b0;
          if (start) begin
            pc_load     = 1'b1;
            pc_load_val = START_ADDR;
            state_d     = FETCH;
          end
        end
        default: begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      out_q   <= '0;
      ipc_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      out_q   <= out_d;
      ipc_q   <= ipc_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic [15:0] fcnt_q;
  logic [15:0] scnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fcnt_q <= '0;
      scnt_q <= '0;
    end else begin
      if (xfer && fcnt_q != 16'hFFFF) begin
        fcnt_q <= fcnt_q + 16'd1;
      end
      if (valid_q && !instr_ready && scnt_q != 16'hFFFF) begin
        scnt_q <= scnt_q + 16'd1;
      end
    end
  end

  assign perf_fetch_cnt = fcnt_q;
  assign perf_stall_cnt = scnt_q;
`else
  logic unused_xfer;
  assign unused_xfer = xfer;
`endif

  assign imem_addr   = pc;
  assign instr_valid = valid_q;
  assign instr_out   = out_q;
  assign instr_pc    = ipc_q;
  assign halted      = (state_q == HALTED);

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl: directed scenarios with literal
// expectations plus randomized traffic checked against a behavioural model.
module tb_instr_fetch_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] imem_addr;
  logic [7:0] imem_data;
  logic       branch_valid = 1'b0;
  logic [7:0] branch_target = 8'h00;
  logic       instr_valid;
  logic       instr_ready = 1'b0;
  logic [7:0] instr_out;
  logic [7:0] instr_pc;
  logic       halted;
`ifdef FETCH_PERF_EN
  logic [15:0] perf_fetch_cnt;
  logic [15:0] perf_stall_cnt;
`endif

  logic [7:0] mem [256];
  assign imem_data = mem[imem_addr];

  int checks = 0;
  int errors = 0;
  bit done = 1'b0;

  always #5 clk = ~clk;

  instr_fetch_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .branch_valid (branch_valid),
    .branch_target(branch_target),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr_out    (instr_out),
    .instr_pc     (instr_pc),
`ifdef FETCH_PERF_EN
    .perf_fetch_cnt(perf_fetch_cnt),
    .perf_stall_cnt(perf_stall_cnt),
`endif
    .halted       (halted)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 running, 2 waiting to hand over
  // the halt word, 3 halted.
  int       m_ph = 0;
  bit [7:0] m_pc = 8'h00;
  bit       m_v = 1'b0;
  bit [7:0] m_word = 8'h00;
  bit [7:0] m_wpc = 8'h00;
  int       m_fetch = 0;
  int       m_stall = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ph = 0; m_pc = 8'h00; m_v = 1'b0;
      m_word = 8'h00; m_wpc = 8'h00;
      m_fetch = 0; m_stall = 0;
    end else begin
      bit redirect;
      redirect = branch_valid && (m_ph == 1 || m_ph == 2);
      if (m_v && instr_ready && !redirect && m_fetch < 65535) m_fetch++;
      if (m_v && !instr_ready && m_stall < 65535) m_stall++;
      if (redirect) begin
        m_v = 1'b0;
        m_pc = branch_target;
        m_ph = 1;
      end else if (m_ph == 0) begin
        if (start) m_ph = 1;
      end else if (m_ph == 3) begin
        if (start) begin
          m_pc = 8'h00;
          m_ph = 1;
        end
      end else if (m_ph == 1) begin
        if (!m_v || instr_ready) begin
          m_word = mem[m_pc];
          m_wpc = m_pc;
          m_v = 1'b1;
          m_pc = m_pc + 8'd1;
          if (m_word == 8'hFF) m_ph = 2;
        end
      end else if (m_v && instr_ready) begin
        m_v = 1'b0;
        m_ph = 3;
      end
    end
  end

  always @(negedge clk) begin
    if (!done) begin
      chk("m_addr", imem_addr, m_pc);
      chk("m_valid", instr_valid, m_v);
      chk("m_halted", halted, m_ph == 3);
      if (m_v) begin
        chk("m_out", instr_out, m_word);
        chk("m_pc", instr_pc, m_wpc);
      end
`ifdef FETCH_PERF_EN
      chk("m_fcnt", perf_fetch_cnt, m_fetch);
      chk("m_scnt", perf_stall_cnt, m_stall);
`endif
    end
  end

  initial begin
    bit found;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 254));
    for (int i = 0; i < 16; i++) mem[i] = 8'(i);
    mem[8'h10] = 8'hFF;
    mem[8'hFF] = 8'h5A;

    repeat (2) @(negedge clk);
    chk("rst_valid", instr_valid, 0);
    chk("rst_addr", imem_addr, 8'h00);
    chk("rst_out", instr_out, 8'h00);
    chk("rst_ipc", instr_pc, 8'h00);
    chk("rst_halted", halted, 0);
    reset = 1'b0;

    // 1: start and stream with ready high
    @(negedge clk);
    start = 1'b1;
    instr_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("s1_notyet", instr_valid, 0);
    @(negedge clk);
    chk("s1_valid", instr_valid, 1);
    chk("s1_out0", instr_out, 8'h00);
    chk("s1_pc0", instr_pc, 8'h00);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("s1_out", instr_out, k);
      chk("s1_pc", instr_pc, k);
    end

    // 2: stall three cycles on word 04
    instr_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("s2_out", instr_out, 8'h04);
      chk("s2_addr", imem_addr, 8'h05);
      chk("s2_valid", instr_valid, 1);
    end
    instr_ready = 1'b1;
    @(negedge clk);
    chk("s2_next", instr_out, 8'h05);
`ifdef FETCH_PERF_EN
    chk("s2_stall", perf_stall_cnt, 3);
    chk("s2_fetch", perf_fetch_cnt, 5);
`endif

    // 3: branch to FF while 06 is on the output
    @(negedge clk);
    chk("s3_pre", instr_out, 8'h06);
    branch_valid = 1'b1;
    branch_target = 8'hFF;
    @(negedge clk);
    branch_valid = 1'b0;
    chk("s3_flush", instr_valid, 0);
    chk("s3_addr", imem_addr, 8'hFF);
    @(negedge clk);
    chk("s3_out", instr_out, 8'h5A);
    chk("s3_pc", instr_pc, 8'hFF);
    @(negedge clk);
    chk("s3_wrap", instr_pc, 8'h00);

    // 4: run into the halt word at 10
    found = 1'b0;
    for (int k = 0; k < 64 && !found; k++) begin
      @(negedge clk);
      if (instr_valid && instr_out == 8'hFF) found = 1'b1;
    end
    chk("s4_found", found, 1);
    chk("s4_pc", instr_pc, 8'h10);
    @(negedge clk);
    chk("s4_valid", instr_valid, 0);
    chk("s4_halted", halted, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("s4_unhalt", halted, 0);
    chk("s4_addr", imem_addr, 8'h00);
    @(negedge clk);
    chk("s4_rvalid", instr_valid, 1);
    chk("s4_rpc", instr_pc, 8'h00);

    // 5: asynchronous reset while stalled
    instr_ready = 1'b0;
    @(negedge clk);
    chk("s5_pre", instr_valid, 1);
    #3 reset = 1'b1;
    #1;
    chk("s5_valid", instr_valid, 0);
    chk("s5_addr", imem_addr, 8'h00);
    @(negedge clk);
    reset = 1'b0;

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      instr_ready = ($urandom_range(0, 3) != 0);
      start = ($urandom_range(0, 19) == 0);
      branch_valid = ($urandom_range(0, 15) == 0);
      branch_target = 8'($urandom);
    end
    @(negedge clk);
    done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
